dma_tag_engine: RTL and testbench

- DMA datapath engine that sits directly downstream of the DMAC host register block. It consumes that block's start level, start pulse and source address, and produces its done pulse, tag-fail count and end write address.
- On each start it reads a record list from source memory over one Avalon-MM master and checks each record's tag word.
- Payload of passing records is buffered and then written contiguously to a destination region.

---
 rtl/dma_tag_engine.sv | 172 +++++++++++++++++
 tb/tb_dma_tag_engine.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_tag_engine.sv
// dma_tag_engine: fetch a tagged record list over Avalon-MM and copy passing payloads to DST_BASE.
// Optional macro DMAC_ENDIAN_SWAP_EN byte-reverses every payload word on the write bus.
module dma_tag_engine #(
    parameter int unsigned RECORD_WORDS = 4,
    parameter logic [31:0] DST_BASE     = 32'h0001_0000,
    parameter logic [15:0] TAG_MAGIC    = 16'hA5C3
) (
    input  logic        iClk,
    input  logic        iRstn,
    input  logic        start_i,
    input  logic        start_trigger_i,
    input  logic [31:0] s_addr_i,
    output logic        done_trigger_o,
    output logic [15:0] tag_fail_nums_o,
    output logic [31:0] end_addr_write_o,
    output logic        busy_o,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest
);

    localparam logic [3:0] LAST_W = 4'(RECORD_WORDS - 2);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_HDR, S_RD_PAY, S_RD_TAG, S_WR_PAY, S_NEXT, S_DONE
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] src_q, src_d;
    logic [31:0] dst_q, dst_d;
    logic [15:0] n_q, n_d;
    logic [15:0] rec_q, rec_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic [15:0] fail_q, fail_d;
    logic [31:0] end_q, end_d;
    logic [31:0] buf_q [16];
    logic [31:0] pay_w;
    logic        xfer_ok;
    logic        abort;
    logic        tag_pass;

    assign xfer_ok  = (avm_read | avm_write) & ~avm_waitrequest;
    assign abort    = ~start_i & (state_q != S_IDLE) & (state_q != S_DONE);
    assign tag_pass = (avm_readdata[31:16] == TAG_MAGIC) &&
                      (avm_readdata[15:0] == rec_q);
    assign pay_w    = buf_q[wcnt_q];

    assign tag_fail_nums_o  = fail_q;
    assign end_addr_write_o = end_q;

    // State register
    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state: advance on completed transfers; abort only once no transfer is pending
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start_trigger_i) state_d = S_RD_HDR;
            S_RD_HDR: if (xfer_ok)
                          state_d = (avm_readdata[15:0] == 16'd0) ? S_DONE : S_RD_PAY;
            S_RD_PAY: if (xfer_ok && wcnt_q == LAST_W) state_d = S_RD_TAG;
            S_RD_TAG: if (xfer_ok) state_d = tag_pass ? S_WR_PAY : S_NEXT;
            S_WR_PAY: if (xfer_ok && wcnt_q == LAST_W) state_d = S_NEXT;
            S_NEXT:   state_d = (rec_q + 16'd1 == n_q) ? S_DONE : S_RD_PAY;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (abort && (state_q == S_NEXT || xfer_ok)) state_d = S_IDLE;
    end

    // Bus and status outputs decoded from the current state
    always_comb begin
        busy_o         = (state_q != S_IDLE);
        done_trigger_o = (state_q == S_DONE);
        avm_read       = 1'b0;
        avm_write      = 1'b0;
        avm_address    = 32'd0;
        avm_writedata  = 32'd0;
        case (state_q)
            S_RD_HDR, S_RD_PAY, S_RD_TAG: begin
                avm_read    = 1'b1;
                avm_address = src_q;
            end
            S_WR_PAY: begin
                avm_write   = 1'b1;
                avm_address = dst_q;
`ifdef DMAC_ENDIAN_SWAP_EN
                avm_writedata = {pay_w[7:0], pay_w[15:8], pay_w[23:16], pay_w[31:24]};
`else
                avm_writedata = pay_w;
`endif
            end
            default: ;
        endcase
    end

    // Datapath next-state: pointers, counters and result registers
    always_comb begin
        src_d  = src_q;
        dst_d  = dst_q;
        n_d    = n_q;
        rec_d  = rec_q;
        wcnt_d = wcnt_q;
        fail_d = fail_q;
        end_d  = end_q;
        case (state_q)
            S_IDLE: if (start_trigger_i) begin
                src_d  = s_addr_i & ~32'd3;
                dst_d  = DST_BASE;
                fail_d = 16'd0;
                rec_d  = 16'd0;
                wcnt_d = 4'd0;
            end
            S_RD_HDR: if (xfer_ok) begin
                n_d   = avm_readdata[15:0];
                src_d = src_q + 32'd4;
            end
            S_RD_PAY: if (xfer_ok) begin
                src_d  = src_q + 32'd4;
                wcnt_d = (wcnt_q == LAST_W) ? 4'd0 : wcnt_q + 4'd1;
            end
            S_RD_TAG: if (xfer_ok) begin
                src_d = src_q + 32'd4;
                if (!tag_pass && fail_q != 16'hFFFF) fail_d = fail_q + 16'd1;
            end
            S_WR_PAY: if (xfer_ok) begin
                dst_d  = dst_q + 32'd4;
                wcnt_d = (wcnt_q == LAST_W) ? 4'd0 : wcnt_q + 4'd1;
            end
            S_NEXT: rec_d = rec_q + 16'd1;
            S_DONE: end_d = dst_q;
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            src_q  <= 32'd0;
            dst_q  <= 32'd0;
            n_q    <= 16'd0;
            rec_q  <= 16'd0;
            wcnt_q <= 4'd0;
            fail_q <= 16'd0;
            end_q  <= 32'd0;
        end else begin
            src_q  <= src_d;
            dst_q  <= dst_d;
            n_q    <= n_d;
            rec_q  <= rec_d;
            wcnt_q <= wcnt_d;
            fail_q <= fail_d;
            end_q  <= end_d;
        end
    end

    // Payload buffer filled word by word during the payload read phase
    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            for (int i = 0; i < 16; i++) buf_q[i] <= 32'd0;
        end else if (state_q == S_RD_PAY && xfer_ok) begin
            buf_q[wcnt_q] <= avm_readdata;
        end
    end

endmodule

// File: tb/tb_dma_tag_engine.sv
// tb_dma_tag_engine: randomized list/stall stimulus checked against a list-walking model.
// Bus slave, transfer log and stability checks live in one negedge process.
module tb_dma_tag_engine;

    localparam int RW = 4;
    localparam logic [31:0] DBASE = 32'h0001_0000;

    logic        iClk = 0;
    logic        iRstn = 0;
    logic        start_i = 0;
    logic        start_trigger_i = 0;
    logic [31:0] s_addr_i = 0;
    logic        done_trigger_o;
    logic [15:0] tag_fail_nums_o;
    logic [31:0] end_addr_write_o;
    logic        busy_o;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest = 0;

    dma_tag_engine dut (
        .iClk(iClk), .iRstn(iRstn), .start_i(start_i),
        .start_trigger_i(start_trigger_i), .s_addr_i(s_addr_i),
        .done_trigger_o(done_trigger_o), .tag_fail_nums_o(tag_fail_nums_o),
        .end_addr_write_o(end_addr_write_o), .busy_o(busy_o),
        .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
        .avm_waitrequest(avm_waitrequest)
    );

    always #5 iClk = ~iClk;

    logic [31:0] mem [4096];
    assign avm_readdata = mem[avm_address[13:2]];

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    bit stall_en = 0;
    bit hold_wr = 0;
    bit armed = 0;
    bit stalled = 0;
    int stalls = 0;
    logic [65:0] snap;
    logic [63:0] wlog [$];
    logic [31:0] rlog [$];

    logic [63:0] exp_w [$];
    logic [15:0] exp_fail;
    logic [31:0] exp_end;
    int          exp_lat;

    always @(posedge iClk) cyc++;

    // Slave: random waitstates, transfer log, stall-stability and exclusivity checks
    always @(negedge iClk) begin
        if (done_trigger_o) begin done_cnt++; done_cyc = cyc; end
        if (stalled) begin
            checks++;
            if ({avm_address, avm_read, avm_write, avm_writedata} !== snap)
                $display("FAIL bus_stable got %h want %h",
                         {avm_address, avm_read, avm_write, avm_writedata}, snap);
            else passes++;
        end
        stalled = 0;
        if (!(avm_read || avm_write)) begin
            avm_waitrequest = 0;
            armed = 0;
        end else if (hold_wr && avm_write) begin
            avm_waitrequest = 1;
            stalled = 1;
            armed = 0;
        end else begin
            if (!armed) begin
                armed = 1;
                stalls = stall_en ? int'($urandom_range(5, 1)) : 0;
            end
            if (stalls > 0) begin
                stalls--;
                avm_waitrequest = 1;
                stalled = 1;
            end else begin
                avm_waitrequest = 0;
                armed = 0;
                checks++;
                if (avm_read && avm_write)
                    $display("FAIL rd_wr_excl got rd=1 wr=1 want one");
                else passes++;
                if (avm_write) wlog.push_back({avm_address, avm_writedata});
                else rlog.push_back(avm_address);
            end
        end
        if (stalled) snap = {avm_address, avm_read, avm_write, avm_writedata};
    end

    function automatic logic [11:0] widx(input logic [31:0] a);
        return a[13:2];
    endfunction

    function automatic logic [31:0] pay_xf(input logic [31:0] w);
`ifdef DMAC_ENDIAN_SWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    // Reference: walk the list in memory and derive writes, fails, end address, latency
    task automatic model_job(input logic [31:0] sa);
        logic [31:0] a, d, tag;
        logic [31:0] pay [$];
        int n;
        exp_w.delete();
        a = {sa[31:2], 2'b00};
        n = int'(mem[widx(a)][15:0]);
        a += 4;
        d = DBASE;
        exp_fail = 0;
        exp_lat = 2;
        for (int r = 0; r < n; r++) begin
            pay.delete();
            for (int k = 0; k < RW - 1; k++) begin
                pay.push_back(mem[widx(a)]);
                a += 4;
            end
            tag = mem[widx(a)];
            a += 4;
            if (tag == {16'hA5C3, 16'(r)}) begin
                foreach (pay[k]) begin
                    exp_w.push_back({d, pay_xf(pay[k])});
                    d += 4;
                end
                exp_lat += 2 * RW;
            end else begin
                if (exp_fail != 16'hFFFF) exp_fail++;
                exp_lat += RW + 1;
            end
        end
        exp_end = d;
    endtask

    // List with sequential payload starting at pay0; records in badmask get a wrong index
    task automatic put_list(input logic [31:0] sa, input int n,
                            input logic [31:0] pay0, input logic [31:0] badmask);
        logic [31:0] a;
        a = {sa[31:2], 2'b00};
        mem[widx(a)] = {16'hBEEF, 16'(n)};
        a += 4;
        for (int r = 0; r < n; r++) begin
            for (int k = 0; k < RW - 1; k++) begin
                mem[widx(a)] = pay0 + 32'(r * (RW - 1) + k);
                a += 4;
            end
            mem[widx(a)] = badmask[r] ? {16'hA5C3, 16'(r) ^ 16'h0006}
                                      : {16'hA5C3, 16'(r)};
            a += 4;
        end
    endtask

    // Pulse start, wait (bounded) for done; optional second trigger ign_at cycles later
    task automatic run_job(input logic [31:0] sa, input int ign_at,
                           output int lat, output int ndone);
        int d0, c0;
        wlog.delete();
        rlog.delete();
        d0 = done_cnt;
        @(negedge iClk); #1;
        s_addr_i = sa;
        start_trigger_i = 1;
        c0 = cyc;
        @(negedge iClk); #1;
        start_trigger_i = 0;
        lat = -1;
        for (int i = 0; i < 3000 && done_cnt == d0; i++) begin
            start_trigger_i = (i == ign_at);
            if (i == ign_at) s_addr_i = 32'h0000_3000;
            @(negedge iClk); #1;
        end
        start_trigger_i = 0;
        if (done_cnt != d0) lat = done_cyc - c0;
        repeat (3) begin @(negedge iClk); #1; end
        ndone = done_cnt - d0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge iClk);
        checks++; if (busy_o !== 1'b0) $display("FAIL rst_busy got %h want 0", busy_o); else passes++;
        checks++; if (done_trigger_o !== 1'b0) $display("FAIL rst_done got %h want 0", done_trigger_o); else passes++;
        #1 iRstn = 1;
        start_i = 1;
        @(negedge iClk); #1;
        checks++; if (tag_fail_nums_o !== 16'd0) $display("FAIL rst_fail got %h want 0", tag_fail_nums_o); else passes++;
        checks++; if (end_addr_write_o !== 32'd0) $display("FAIL rst_end got %h want 0", end_addr_write_o); else passes++;
        checks++; if ({avm_read, avm_write} !== 2'b00) $display("FAIL rst_req got %b want 00", {avm_read, avm_write}); else passes++;
        checks++; if (avm_address !== 32'd0) $display("FAIL rst_addr got %h want 0", avm_address); else passes++;
        checks++; if (avm_writedata !== 32'd0) $display("FAIL rst_wdata got %h want 0", avm_writedata); else passes++;
        checks++; if (busy_o !== 1'b0) $display("FAIL rst_busy2 got %h want 0", busy_o); else passes++;
    endtask

    task automatic test_basic(input bit stall, input string nm);
        int lat, nd;
        logic [63:0] g;
        stall_en = stall;
        put_list(32'h0000_1000, 2, 32'd1, 32'd0);
        model_job(32'h0000_1000);
        run_job(32'h0000_1000, -1, lat, nd);
        checks++; if (wlog.size() != 6) $display("FAIL %s_nwr got %0d want 6", nm, wlog.size()); else passes++;
        foreach (exp_w[i]) begin
            g = (i < wlog.size()) ? wlog[i] : 64'hx;
            checks++; if (g !== exp_w[i]) $display("FAIL %s_wr%0d got %h want %h", nm, i, g, exp_w[i]); else passes++;
        end
        g = (wlog.size() > 5) ? wlog[5] : 64'hx;
        checks++; if (g !== {32'h0001_0014, pay_xf(32'd6)}) $display("FAIL %s_last got %h want %h", nm, g, {32'h0001_0014, pay_xf(32'd6)}); else passes++;
        checks++; if (tag_fail_nums_o !== 16'd0) $display("FAIL %s_fail got %h want 0", nm, tag_fail_nums_o); else passes++;
        checks++; if (end_addr_write_o !== 32'h0001_0018) $display("FAIL %s_end got %h want 10018", nm, end_addr_write_o); else passes++;
        checks++; if (nd !== 1) $display("FAIL %s_ndone got %0d want 1", nm, nd); else passes++;
        if (!stall) begin
            checks++; if (lat !== exp_lat) $display("FAIL %s_lat got %0d want %0d", nm, lat, exp_lat); else passes++;
        end
        stall_en = 0;
    endtask

    task automatic test_tag_fail();
        int lat, nd;
        logic [63:0] g;
        put_list(32'h0000_1000, 3, 32'h100, 32'b010);
        model_job(32'h0000_1000);
        run_job(32'h0000_1000, -1, lat, nd);
        checks++; if (wlog.size() != exp_w.size()) $display("FAIL tf_nwr got %0d want %0d", wlog.size(), exp_w.size()); else passes++;
        foreach (exp_w[i]) begin
            g = (i < wlog.size()) ? wlog[i] : 64'hx;
            checks++; if (g !== exp_w[i]) $display("FAIL tf_wr%0d got %h want %h", i, g, exp_w[i]); else passes++;
        end
        checks++; if (tag_fail_nums_o !== 16'd1) $display("FAIL tf_fail got %h want 1", tag_fail_nums_o); else passes++;
        checks++; if (end_addr_write_o !== 32'h0001_0018) $display("FAIL tf_end got %h want 10018", end_addr_write_o); else passes++;
        checks++; if (lat !== exp_lat) $display("FAIL tf_lat got %0d want %0d", lat, exp_lat); else passes++;
        checks++; if (nd !== 1) $display("FAIL tf_ndone got %0d want 1", nd); else passes++;
    endtask

    task automatic test_zero();
        int lat, nd;
        logic [31:0] ra;
        mem[widx(32'h2000)] = 32'h1234_0000;
        run_job(32'h0000_2003, -1, lat, nd);
        ra = (rlog.size() > 0) ? rlog[0] : 32'hx;
        checks++; if (ra !== 32'h0000_2000) $display("FAIL zero_hdr got %h want 2000", ra); else passes++;
        checks++; if (wlog.size() != 0) $display("FAIL zero_nwr got %0d want 0", wlog.size()); else passes++;
        checks++; if (lat !== 2) $display("FAIL zero_lat got %0d want 2", lat); else passes++;
        checks++; if (end_addr_write_o !== DBASE) $display("FAIL zero_end got %h want %h", end_addr_write_o, DBASE); else passes++;
        checks++; if (nd !== 1) $display("FAIL zero_ndone got %0d want 1", nd); else passes++;
    endtask

    task automatic test_random();
        int lat, nd, n, kind;
        logic [31:0] sa, a;
        logic [63:0] g;
        for (int it = 0; it < 8; it++) begin
            stall_en = $urandom_range(1, 0);
            n = $urandom_range(4, 0);
            sa = 32'h0000_1000 | 32'($urandom_range(3, 0));
            a = 32'h0000_1000;
            mem[widx(a)] = {16'($urandom), 16'(n)};
            a += 4;
            for (int r = 0; r < n; r++) begin
                for (int k = 0; k < RW - 1; k++) begin
                    mem[widx(a)] = $urandom;
                    a += 4;
                end
                kind = $urandom_range(2, 0);
                mem[widx(a)] = (kind == 0) ? {16'hA5C3, 16'(r)} :
                               (kind == 1) ? {16'hA5C2, 16'(r)} :
                                             {16'hA5C3, 16'(r + 1)};
                a += 4;
            end
            model_job(sa);
            run_job(sa, -1, lat, nd);
            checks++; if (wlog.size() != exp_w.size()) $display("FAIL rnd%0d_nwr got %0d want %0d", it, wlog.size(), exp_w.size()); else passes++;
            foreach (exp_w[i]) begin
                g = (i < wlog.size()) ? wlog[i] : 64'hx;
                checks++; if (g !== exp_w[i]) $display("FAIL rnd%0d_wr%0d got %h want %h", it, i, g, exp_w[i]); else passes++;
            end
            checks++; if (tag_fail_nums_o !== exp_fail) $display("FAIL rnd%0d_fail got %h want %h", it, tag_fail_nums_o, exp_fail); else passes++;
            checks++; if (end_addr_write_o !== exp_end) $display("FAIL rnd%0d_end got %h want %h", it, end_addr_write_o, exp_end); else passes++;
            checks++; if (nd !== 1) $display("FAIL rnd%0d_ndone got %0d want 1", it, nd); else passes++;
            if (!stall_en) begin
                checks++; if (lat !== exp_lat) $display("FAIL rnd%0d_lat got %0d want %0d", it, lat, exp_lat); else passes++;
            end
        end
        stall_en = 0;
    endtask

    task automatic test_swap_ignore();
        int lat, nd;
        logic [63:0] g;
        logic [31:0] wantd;
        put_list(32'h0000_3000, 1, 32'hDEAD_0000, 32'd0);
        put_list(32'h0000_1000, 2, 32'h1122_3344, 32'd0);
        model_job(32'h0000_1000);
        stall_en = 1;
        run_job(32'h0000_1000, 4, lat, nd);
        stall_en = 0;
`ifdef DMAC_ENDIAN_SWAP_EN
        wantd = 32'h4433_2211;
`else
        wantd = 32'h1122_3344;
`endif
        g = (wlog.size() > 0) ? wlog[0] : 64'hx;
        checks++; if (g !== {DBASE, wantd}) $display("FAIL swap_w0 got %h want %h", g, {DBASE, wantd}); else passes++;
        checks++; if (wlog.size() != exp_w.size()) $display("FAIL ign_nwr got %0d want %0d", wlog.size(), exp_w.size()); else passes++;
        foreach (exp_w[i]) begin
            g = (i < wlog.size()) ? wlog[i] : 64'hx;
            checks++; if (g !== exp_w[i]) $display("FAIL ign_wr%0d got %h want %h", i, g, exp_w[i]); else passes++;
        end
        checks++; if (end_addr_write_o !== exp_end) $display("FAIL ign_end got %h want %h", end_addr_write_o, exp_end); else passes++;
        checks++; if (nd !== 1) $display("FAIL ign_ndone got %0d want 1", nd); else passes++;
    endtask

    task automatic test_abort();
        int d0, i;
        logic [31:0] prev_end;
        logic [63:0] g;
        put_list(32'h0000_1000, 2, 32'h0000_0A00, 32'd0);
        prev_end = end_addr_write_o;
        wlog.delete();
        d0 = done_cnt;
        hold_wr = 1;
        @(negedge iClk); #1;
        s_addr_i = 32'h0000_1000;
        start_trigger_i = 1;
        @(negedge iClk); #1;
        start_trigger_i = 0;
        for (i = 0; i < 200 && !avm_write; i++) begin @(negedge iClk); #1; end
        checks++; if (avm_write !== 1'b1) $display("FAIL abort_reach got wr=%b want 1", avm_write); else passes++;
        start_i = 0;
        repeat (3) begin @(negedge iClk); #1; end
        checks++; if ({busy_o, avm_write} !== 2'b11) $display("FAIL abort_held got %b want 11", {busy_o, avm_write}); else passes++;
        checks++; if (avm_address !== DBASE) $display("FAIL abort_addr got %h want %h", avm_address, DBASE); else passes++;
        hold_wr = 0;
        for (i = 0; i < 50 && busy_o; i++) begin @(negedge iClk); #1; end
        repeat (3) begin @(negedge iClk); #1; end
        checks++; if (busy_o !== 1'b0) $display("FAIL abort_idle got %b want 0", busy_o); else passes++;
        checks++; if (wlog.size() != 1) $display("FAIL abort_nwr got %0d want 1", wlog.size()); else passes++;
        g = (wlog.size() > 0) ? wlog[0] : 64'hx;
        checks++; if (g !== {DBASE, pay_xf(32'h0000_0A00)}) $display("FAIL abort_wr got %h want %h", g, {DBASE, pay_xf(32'h0000_0A00)}); else passes++;
        checks++; if (done_cnt - d0 !== 0) $display("FAIL abort_done got %0d want 0", done_cnt - d0); else passes++;
        checks++; if (end_addr_write_o !== prev_end) $display("FAIL abort_end got %h want %h", end_addr_write_o, prev_end); else passes++;
        start_i = 1;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'd0;
        test_reset();
        test_basic(0, "basic");
        test_tag_fail();
        test_zero();
        test_basic(1, "stall");
        test_swap_ignore();
        test_random();
        put_list(32'h0000_1000, 1, 32'd5, 32'd0);
        test_abort();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
